// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the 4-beat x 64-bit burst memory responder.
package burst_mem_pkg;

   localparam int unsigned BEATS       = 4;
   localparam int unsigned BEAT_W      = 64;
   localparam int unsigned LINE_W      = 256;
   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned OFFSET_BITS = 5;
   localparam int unsigned BEAT_IDX_W  = 2;
   // Wide enough for LATENCY (max 31) plus the optional random extra (max 15)
   localparam int unsigned CNT_W       = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef logic [BEAT_IDX_W-1:0] beat_t;

endpackage

// File: rtl/burst_mem_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) adding random latency.
// Present only when BURST_MEM_RAND_LAT_EN is defined.
`ifdef BURST_MEM_RAND_LAT_EN
module burst_mem_lfsr (
   input  logic       clk,
   input  logic       reset_n,
   output logic [7:0] lfsr
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr <= 8'hA5;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

endmodule
`endif

// File: rtl/burst_mem_responder.sv
// Memory end of the 4-beat x 64-bit burst link, backed by LINES x 256-bit storage.
// BURST_MEM_RAND_LAT_EN adds an LFSR-driven extra latency of 0..15 cycles.
module burst_mem_responder
   import burst_mem_pkg::*;
#(
   parameter int unsigned LINES   = 16,
   parameter int unsigned LATENCY = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              read_i,
   input  logic              write_i,
   input  logic [ADDR_W-1:0] address_i,
   input  logic [BEAT_W-1:0] burst_i,
   output logic [BEAT_W-1:0] burst_o,
   output logic              resp_o,
   output logic              err_o
);

   localparam int unsigned IDX_W  = $clog2(LINES);
   localparam int unsigned WORDS  = LINES * BEATS;

   state_t               state;
   logic                 is_write;
   logic [IDX_W-1:0]     idx;
   beat_t                beat;
   beat_t                beat_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     lat_eff;
   logic [IDX_W-1:0]     req_idx;
   logic                 unused_addr;

   logic [BEAT_W-1:0]    mem [WORDS];

   assign req_idx     = address_i[OFFSET_BITS +: IDX_W];
   assign beat_nxt    = beat_t'(beat + beat_t'(1));
   assign unused_addr = ^address_i;

`ifdef BURST_MEM_RAND_LAT_EN
   logic [7:0] lfsr;
   logic       unused_lfsr;

   burst_mem_lfsr u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .lfsr    (lfsr)
   );

   assign lat_eff     = CNT_W'(LATENCY) + CNT_W'(lfsr[3:0]);
   assign unused_lfsr = ^lfsr[7:4];
`else
   assign lat_eff = CNT_W'(LATENCY);
`endif

   // Control FSM; burst_o is prefetched one edge ahead so it is valid with resp_o
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         is_write <= 1'b0;
         idx      <= '0;
         beat     <= '0;
         cnt      <= '0;
         resp_o   <= 1'b0;
         burst_o  <= '0;
         err_o    <= 1'b0;
      end else begin
         if (read_i && write_i) begin
            err_o <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (read_i ^ write_i) begin
                  is_write <= write_i;
                  idx      <= req_idx;
                  beat     <= '0;
                  cnt      <= lat_eff;
                  if (lat_eff == '0) begin
                     state  <= BURST;
                     resp_o <= 1'b1;
                     if (!write_i) begin
                        burst_o <= mem[{req_idx, beat_t'(0)}];
                     end
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == CNT_W'(1)) begin
                  state  <= BURST;
                  resp_o <= 1'b1;
                  cnt    <= '0;
                  if (!is_write) begin
                     burst_o <= mem[{idx, beat_t'(0)}];
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            BURST: begin
               if (beat == beat_t'(BEATS - 1)) begin
                  state  <= DONE;
                  resp_o <= 1'b0;
                  beat   <= '0;
               end else begin
                  beat <= beat_nxt;
                  if (!is_write) begin
                     burst_o <= mem[{idx, beat_nxt}];
                  end
               end
            end
            DONE: begin
               if (!read_i && !write_i) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Storage is not reset; a write beat lands at the edge ending its resp_o cycle
   always_ff @(posedge clk) begin
      if (state == BURST && is_write) begin
         mem[{idx, beat}] <= burst_i;
      end
   end

endmodule
